// File: rtl/uart_transmit.sv
// UART transmitter: 8 data bits, LSB first, STOP_BITS stop bits, CLKS_PER_BIT clocks per bit.
// Define UART_TRANSMIT_PARITY_EN to insert an even-parity bit between bit 7 and the stop bit(s).
module uart_transmit #(
   parameter int CLKS_PER_BIT = 27,
   parameter int STOP_BITS    = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] DATA,
   input  logic       TXD_VALID,
   output logic       TXD_READY,
   output logic       TXD
);

   localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
   localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TRANSMIT_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        stop_idx_q, stop_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        txd_q, txd_d;
`ifdef UART_TRANSMIT_PARITY_EN
   logic        parity_q, parity_d;
`endif

   logic bit_end;
   logic last_stop_cycle;

   assign bit_end         = (cnt_q == LAST_CNT);
   assign last_stop_cycle = (state_q == S_STOP) && (stop_idx_q == LAST_STOP) && bit_end;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         txd_q      <= 1'b1;
`ifdef UART_TRANSMIT_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
`ifdef UART_TRANSMIT_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   // A new byte is loaded from IDLE or from the last stop cycle, so frames chain without a gap.
   always_comb begin
      state_d    = state_q;
      cnt_d      = bit_end ? '0 : cnt_q + 16'd1;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
`ifdef UART_TRANSMIT_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (TXD_VALID) begin
               state_d    = S_START;
               shift_d    = DATA;
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
`ifdef UART_TRANSMIT_PARITY_EN
               parity_d   = ^DATA;
`endif
            end
         end
         S_START: begin
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  stop_idx_d = 1'b0;
`ifdef UART_TRANSMIT_PARITY_EN
                  state_d    = S_PARITY;
`else
                  state_d    = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
`ifdef UART_TRANSMIT_PARITY_EN
         S_PARITY: begin
            if (bit_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (last_stop_cycle) begin
               if (TXD_VALID) begin
                  state_d    = S_START;
                  shift_d    = DATA;
                  bit_idx_d  = '0;
                  stop_idx_d = 1'b0;
`ifdef UART_TRANSMIT_PARITY_EN
                  parity_d   = ^DATA;
`endif
               end else begin
                  state_d = S_IDLE;
               end
            end else if (bit_end) begin
               stop_idx_d = stop_idx_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // TXD is registered from the next state so the line changes on the same edge as the state.
   always_comb begin
      TXD_READY = (state_q == S_IDLE) || last_stop_cycle;
      case (state_d)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shift_d[0];
`ifdef UART_TRANSMIT_PARITY_EN
         S_PARITY: txd_d = parity_d;
`endif
         default:  txd_d = 1'b1;
      endcase
   end

   assign TXD = txd_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit: table of bytes through a frame-level scoreboard, plus
// back-to-back, ignored-request, reset-abort and two-stop-bit sequences.
module tb_uart_transmit;

   localparam int CLKS = 27;
`ifdef UART_TRANSMIT_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NBITS = 10 + PAR;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       txd;
   logic [7:0] data2;
   logic       valid2;
   logic       ready2;
   logic       txd2;

   always #5 clk = ~clk;

   uart_transmit #(.CLKS_PER_BIT(CLKS), .STOP_BITS(1)) dut (
      .CLK(clk), .RST(rst_n), .DATA(data), .TXD_VALID(valid), .TXD_READY(ready), .TXD(txd)
   );

   uart_transmit #(.CLKS_PER_BIT(CLKS), .STOP_BITS(2)) dut2 (
      .CLK(clk), .RST(rst_n), .DATA(data2), .TXD_VALID(valid2), .TXD_READY(ready2), .TXD(txd2)
   );

   typedef struct {
      logic [11:0] bits;
      int          nbits;
      longint      accept;
   } frame_t;

   typedef struct {
      logic [7:0] data;
      logic       par;
   } vec_t;

   frame_t sb[$];
   vec_t   vectors[8];

   int     n_checks = 0;
   int     n_fail   = 0;
   longint cycle_cnt = 0;
   longint last_end  = 0;
   bit     mon_busy  = 1'b0;
   bit     mon_abort = 1'b0;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Line levels in transmission order: start, d0..d7, optional parity, then stop ones.
   function automatic logic [11:0] make_frame(input logic [7:0] d, input logic p);
      logic [11:0] f;
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = d[i];
      if (PAR == 1) f[9] = p;
      return f;
   endfunction

   // Called on a negedge; returns on the negedge right after the acceptance edge.
   task automatic applyStimulus(input logic [7:0] d, input logic p, input bit hold);
      int     waited;
      frame_t f;
      data   = d;
      valid  = 1'b1;
      waited = 0;
      while (ready !== 1'b1 && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      if (ready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL accept_timeout actual=ready_low required=ready_high");
         valid = 1'b0;
         return;
      end
      f.bits   = make_frame(d, p);
      f.nbits  = NBITS;
      f.accept = cycle_cnt + 1;
      sb.push_back(f);
      @(posedge clk);
      @(negedge clk);
      if (!hold) valid = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!mon_busy && sb.size() == 0 && ready === 1'b1) return;
         @(negedge clk);
      end
      n_checks++;
      n_fail++;
      $display("[TB] FAIL idle_timeout actual=busy required=idle");
   endtask

   // Frame monitor: pops the expected frame at the start bit and checks every cycle of every bit.
   initial begin
      frame_t cur;
      int     bit_i;
      int     cyc_i;
      int     bit_err;
      int     rdy_err;
      int     fr_n;
      bit     spurious;
      bit     exp_rdy;
      bit_i = 0; cyc_i = 0; bit_err = 0; rdy_err = 0; fr_n = 0; spurious = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_abort) begin
            mon_busy  = 1'b0;
            mon_abort = 1'b0;
            continue;
         end
         if (!mon_busy && rst_n === 1'b1 && txd === 1'b0) begin
            if (sb.size() == 0) begin
               if (!spurious) begin
                  n_checks++;
                  n_fail++;
                  $display("[TB] FAIL unexpected_start actual=txd_low required=txd_high");
               end
               spurious = 1'b1;
            end else begin
               cur      = sb.pop_front();
               mon_busy = 1'b1;
               bit_i    = 0;
               cyc_i    = 0;
               bit_err  = 0;
               rdy_err  = 0;
               fr_n++;
               checkOutput($sformatf("frame%0d_start_latency", fr_n), int'(cycle_cnt - cur.accept), 0);
            end
         end
         if (txd === 1'b1) spurious = 1'b0;
         if (mon_busy) begin
            if (txd !== cur.bits[bit_i]) bit_err++;
            exp_rdy = (bit_i == cur.nbits - 1) && (cyc_i == CLKS - 1);
            if (ready !== exp_rdy) rdy_err++;
            cyc_i++;
            if (cyc_i == CLKS) begin
               checkOutput($sformatf("frame%0d_bit%0d_bad_cycles", fr_n, bit_i), bit_err, 0);
               bit_err = 0;
               cyc_i   = 0;
               bit_i++;
               if (bit_i == cur.nbits) begin
                  checkOutput($sformatf("frame%0d_ready_bad_cycles", fr_n), rdy_err, 0);
                  mon_busy = 1'b0;
                  last_end = cycle_cnt;
               end
            end
         end
      end
   end

   // Two-stop-bit instance: 0x81 with the next byte offered throughout.
   task automatic runStop2();
      logic [11:0] f;
      int          bad;
      int          highs;
      int          rdy_bad;
      f       = make_frame(8'h81, 1'b0);
      rdy_bad = 0;
      data2   = 8'h81;
      valid2  = 1'b1;
      checkOutput("s2_ready_idle", 32'(ready2), 1);
      @(posedge clk);
      @(negedge clk);
      for (int b = 0; b < 9 + PAR; b++) begin
         bad = 0;
         for (int c = 0; c < CLKS; c++) begin
            if (txd2 !== f[b]) bad++;
            if (ready2 !== 1'b0) rdy_bad++;
            @(negedge clk);
         end
         checkOutput($sformatf("s2_bit%0d_bad_cycles", b), bad, 0);
      end
      highs = 0;
      for (int c = 0; c < 200; c++) begin
         if (txd2 !== 1'b1) break;
         highs++;
         if (ready2 !== (highs == 2 * CLKS)) rdy_bad++;
         @(negedge clk);
      end
      checkOutput("s2_stop_high_cycles", highs, 2 * CLKS);
      checkOutput("s2_next_start", 32'(txd2), 0);
      checkOutput("s2_ready_bad_cycles", rdy_bad, 0);
      valid2 = 1'b0;
      repeat ((11 + PAR) * CLKS + 5) @(negedge clk);
      checkOutput("s2_idle_after", 32'(txd2), 1);
   endtask

   initial begin
      longint first_accept;
      vectors[0] = '{8'h55, 1'b0};
      vectors[1] = '{8'h07, 1'b1};
      vectors[2] = '{8'hFF, 1'b0};
      vectors[3] = '{8'h01, 1'b1};
      vectors[4] = '{8'h80, 1'b1};
      vectors[5] = '{8'hA5, 1'b0};
      vectors[6] = '{8'h3C, 1'b0};
      vectors[7] = '{8'hC3, 1'b0};

      rst_n  = 1'b0;
      valid  = 1'b0;
      data   = 8'h00;
      valid2 = 1'b0;
      data2  = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("reset_txd", 32'(txd), 1);
      checkOutput("reset_ready", 32'(ready), 1);
      checkOutput("reset_txd2", 32'(txd2), 1);
      checkOutput("reset_ready2", 32'(ready2), 1);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vectors[i].data, vectors[i].par, 1'b0);
         waitIdle(2000);
      end

      repeat (50) @(negedge clk);
      checkOutput("idle_hold_txd", 32'(txd), 1);
      checkOutput("idle_hold_ready", 32'(ready), 1);

      // 0xAA then 0x00 with TXD_VALID held high between them
      applyStimulus(8'hAA, 1'b0, 1'b1);
      first_accept = cycle_cnt;
      applyStimulus(8'h00, 1'b0, 1'b0);
      waitIdle(2000);
      checkOutput("b2b_total_cycles", int'(last_end - first_accept + 1), 2 * NBITS * CLKS);

      // request pulse with 0xFF while 0x0F is on the line
      applyStimulus(8'h0F, 1'b0, 1'b0);
      repeat (60) @(negedge clk);
      checkOutput("midframe_ready", 32'(ready), 0);
      data  = 8'hFF;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      waitIdle(2000);

      // reset pulse during data bit 3 aborts the frame
      applyStimulus(8'hC3, 1'b0, 1'b0);
      repeat (113) @(negedge clk);
      mon_abort = 1'b1;
      rst_n     = 1'b0;
      @(negedge clk);
      checkOutput("abort_txd", 32'(txd), 1);
      checkOutput("abort_ready", 32'(ready), 1);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(8'h3C, 1'b0, 1'b0);
      waitIdle(2000);

      runStop2();
      waitIdle(100);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_transmit.md
UART_TRANSMIT -- requirements
Module: uart_transmit

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 27, meaning clock cycles per UART bit (27 MHz CLK at 1 Mbaud); legal range 2..65535.
REQ-002 SHALL provide parameter STOP_BITS, default 1, meaning number of stop bits per frame; legal values 1 or 2.
REQ-003 SHALL provide port CLK  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL provide port RST  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port DATA  input  8  byte to transmit, sampled only on acceptance.
REQ-006 SHALL provide port TXD_VALID  input  1  request to send DATA.
REQ-007 SHALL provide port TXD_READY  output  1  transmitter can accept a byte this cycle.
REQ-008 SHALL provide port TXD  output  1  serial line, idle high, registered output.

Function
REQ-009 SHALL accept a byte on any rising edge where TXD_VALID=1 and TXD_READY=1, latching DATA into an internal shift register.
REQ-010 SHALL ignore TXD_VALID and DATA while TXD_READY=0; in-flight frame contents SHALL NOT change.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (only with REQ-020), STOP; IDLE->START on acceptance, START->DATA, DATA->PARITY/STOP after bit 7, STOP->IDLE after last stop bit, or STOP->START on acceptance in its final cycle.
REQ-012 SHALL drive TXD=0 beginning the first cycle after the acceptance edge (latency 1 clock).
REQ-013 SHALL hold every bit (start, data, parity, stop) on TXD for exactly CLKS_PER_BIT cycles, timed by a bit-period counter reset at each bit boundary.
REQ-014 SHALL send data bits LSB first, bit 0 immediately after the start bit.
REQ-015 SHALL drive TXD=1 for STOP_BITS*CLKS_PER_BIT cycles after the last data/parity bit.
REQ-016 SHALL assert TXD_READY in IDLE and during the final cycle of the final stop bit only; deasserted in all other states.
REQ-017 SHALL, on acceptance in the final stop cycle, begin the next start bit on the following cycle with no idle gap; frame length exactly (10+STOP_BITS-1)*CLKS_PER_BIT cycles (plus CLKS_PER_BIT with parity).
REQ-018 SHALL keep TXD=1 in IDLE indefinitely while TXD_VALID=0.

Reset
REQ-019 SHALL, on any rising edge with RST=0, go to IDLE, set TXD=1, TXD_READY=1, clear bit counter and shift register; a frame in progress SHALL be aborted, not resumed; acceptance SHALL NOT occur on an edge with RST=0.

Configuration
REQ-020 SHALL, when macro UART_TRANSMIT_PARITY_EN is defined, insert one even-parity bit (XOR of the 8 data bits) of CLKS_PER_BIT cycles between bit 7 and the stop bit(s).
REQ-021 SHALL, when UART_TRANSMIT_PARITY_EN is undefined, contain no PARITY state and send 8N(STOP_BITS) frames.

Verification
REQ-022 SHALL cover: CLKS_PER_BIT=27, send 0x55 -> TXD 0,1,0,1,0,1,0,1,0,1 each held 27 cycles (1000 ns), first low one cycle after acceptance, TXD_READY high in last stop cycle.
REQ-023 SHALL cover: 0xAA then 0x00 offered back-to-back with TXD_VALID held high -> second start bit immediately follows 27-cycle stop bit, 540 cycles total, no idle gap.
REQ-024 SHALL cover: TXD_VALID pulsed with DATA=0xFF mid-frame of 0x0F -> pulse ignored, frame bits 0,1,1,1,1,0,0,0,0,1 unchanged.
REQ-025 SHALL cover: RST=0 for one cycle during data bit 3 -> next cycle TXD=1, TXD_READY=1; subsequent 0x3C sends a clean full frame.
REQ-026 SHALL cover: with UART_TRANSMIT_PARITY_EN, 0x55 -> parity bit 0; 0x07 -> parity bit 1; frame 11 bits, 297 cycles at STOP_BITS=1.
REQ-027 SHALL cover: STOP_BITS=2, send 0x81 -> TXD high 54 cycles after bit 7 before TXD_READY-gated next start.
